// File: rtl/rv64_isa_pkg.sv
// Shared RV64I opcode constants, issue-stage FSM encoding and per-opcode
// register-usage helpers for the decode/issue slice.
package rv64_isa_pkg;

  localparam int XLEN = 64;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_FENCE     = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_OPERAND = 2'd2,
    ST_ISSUE   = 2'd3
  } iss_state_e;

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_STORE,
      OPC_OP, OPC_OP_32, OPC_BRANCH, OPC_JALR: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_STORE, OPC_OP, OPC_OP_32, OPC_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_OP, OPC_OP_32,
      OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/rv64_imm_gen.sv
// Combinational RV64I immediate generator: sign-extends the I/S/B/U/J field
// selected by the opcode and flags opcodes outside the recognised set.
import rv64_isa_pkg::*;

module rv64_imm_gen (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic s;
  assign s = inst[31];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR, OPC_SYSTEM, OPC_FENCE:
        imm = {{52{s}}, inst[31:20]};
      OPC_STORE:
        imm = {{52{s}}, inst[31:25], inst[11:7]};
      OPC_BRANCH:
        imm = {{51{s}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm = {{32{s}}, inst[31:12], 12'b0};
      OPC_JAL:
        imm = {{43{s}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_OP, OPC_OP_32:
        imm = '0;
      default:
        illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv64_issue_stage.sv
// RV64I decode/issue stage: accepts one instruction, interlocks RAW hazards on a
// 32-entry pending-write scoreboard, reads the register file and issues to execute.
import rv64_isa_pkg::*;

module rv64_issue_stage (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_inst_valid,
  output logic            o_inst_ready,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_read0,
  output logic            o_read1,
  output logic [4:0]      o_read_addr0,
  output logic [4:0]      o_read_addr1,
  input  logic [XLEN-1:0] i_read_data0,
  input  logic [XLEN-1:0] i_read_data1,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_addr,
  output logic            o_iss_valid,
  input  logic            i_iss_ready,
  output logic [XLEN-1:0] o_iss_pc,
  output logic [6:0]      o_iss_opcode,
  output logic [2:0]      o_iss_funct3,
  output logic [6:0]      o_iss_funct7,
  output logic [4:0]      o_iss_rd,
  output logic [XLEN-1:0] o_iss_imm,
  output logic [XLEN-1:0] o_iss_rs1_data,
  output logic [XLEN-1:0] o_iss_rs2_data,
  output logic            o_iss_illegal
);

  iss_state_e      state;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     sb;
  logic [31:0]     sb_set;
  logic [31:0]     sb_clr;

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic            use1, use2, wr_rd;
  logic            haz1, haz2, leave_decode;
  logic            inst_hs;
  logic [XLEN-1:0] imm_d;
  logic            illegal_d;

  assign opc   = inst_q[6:0];
  assign rd    = inst_q[11:7];
  assign rs1   = inst_q[19:15];
  assign rs2   = inst_q[24:20];
  assign use1  = uses_rs1(opc);
  assign use2  = uses_rs2(opc);
  assign wr_rd = writes_rd(opc);

  rv64_imm_gen u_imm_gen (
    .inst    (inst_q),
    .imm     (imm_d),
    .illegal (illegal_d)
  );

  // A writeback landing this cycle is forwarded by the register file, so it releases the stall.
  assign haz1 = use1 && (rs1 != 5'd0) && sb[rs1] && !(i_wb_valid && (i_wb_addr == rs1));
  assign haz2 = use2 && (rs2 != 5'd0) && sb[rs2] && !(i_wb_valid && (i_wb_addr == rs2));
  assign leave_decode = (state == ST_DECODE) && !haz1 && !haz2;

  assign o_read0      = leave_decode && use1;
  assign o_read1      = leave_decode && use2;
  assign o_read_addr0 = (state == ST_DECODE) ? rs1 : 5'd0;
  assign o_read_addr1 = (state == ST_DECODE) ? rs2 : 5'd0;

  assign o_inst_ready = (state == ST_IDLE) || ((state == ST_ISSUE) && i_iss_ready);
  assign inst_hs      = i_inst_valid && o_inst_ready;

  assign sb_set = (leave_decode && wr_rd && (rd != 5'd0)) ? (32'd1 << rd) : 32'd0;
  assign sb_clr = i_wb_valid ? (32'd1 << i_wb_addr) : 32'd0;

  always_ff @(posedge i_clk) begin
    if (inst_hs) begin
      inst_q <= i_inst;
      pc_q   <= i_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      sb             <= '0;
      o_iss_valid    <= 1'b0;
      o_iss_pc       <= '0;
      o_iss_opcode   <= '0;
      o_iss_funct3   <= '0;
      o_iss_funct7   <= '0;
      o_iss_rd       <= '0;
      o_iss_imm      <= '0;
      o_iss_rs1_data <= '0;
      o_iss_rs2_data <= '0;
      o_iss_illegal  <= 1'b0;
    end else begin
      sb <= ((sb & ~sb_clr) | sb_set) & ~32'd1;
      case (state)
        ST_IDLE:
          if (inst_hs) state <= ST_DECODE;
        ST_DECODE:
          if (leave_decode) state <= ST_OPERAND;
        // Read data returned for the request made in DECODE is captured here.
        ST_OPERAND: begin
          o_iss_pc       <= pc_q;
          o_iss_opcode   <= opc;
          o_iss_funct3   <= inst_q[14:12];
          o_iss_funct7   <= inst_q[31:25];
          o_iss_rd       <= rd;
          o_iss_imm      <= imm_d;
          o_iss_rs1_data <= use1 ? i_read_data0 : '0;
          o_iss_rs2_data <= use2 ? i_read_data1 : '0;
          o_iss_illegal  <= illegal_d;
          o_iss_valid    <= 1'b1;
          state          <= ST_ISSUE;
        end
        ST_ISSUE:
          if (i_iss_ready) begin
            o_iss_valid <= 1'b0;
            state       <= inst_hs ? ST_DECODE : ST_IDLE;
          end
        default:
          state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv64_issue_stage.sv
// Directed bench for rv64_issue_stage with a one-cycle-latency register-file model
// whose read data encodes the requested address.
module tb_rv64_issue_stage;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_inst_valid;
  logic        o_inst_ready;
  logic [31:0] i_inst;
  logic [63:0] i_pc;
  logic        o_read0, o_read1;
  logic [4:0]  o_read_addr0, o_read_addr1;
  logic [63:0] i_read_data0, i_read_data1;
  logic        i_wb_valid;
  logic [4:0]  i_wb_addr;
  logic        o_iss_valid;
  logic        i_iss_ready;
  logic [63:0] o_iss_pc;
  logic [6:0]  o_iss_opcode;
  logic [2:0]  o_iss_funct3;
  logic [6:0]  o_iss_funct7;
  logic [4:0]  o_iss_rd;
  logic [63:0] o_iss_imm;
  logic [63:0] o_iss_rs1_data, o_iss_rs2_data;
  logic        o_iss_illegal;

  int checks = 0;
  int errors = 0;

  rv64_issue_stage dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_inst_valid   (i_inst_valid),
    .o_inst_ready   (o_inst_ready),
    .i_inst         (i_inst),
    .i_pc           (i_pc),
    .o_read0        (o_read0),
    .o_read1        (o_read1),
    .o_read_addr0   (o_read_addr0),
    .o_read_addr1   (o_read_addr1),
    .i_read_data0   (i_read_data0),
    .i_read_data1   (i_read_data1),
    .i_wb_valid     (i_wb_valid),
    .i_wb_addr      (i_wb_addr),
    .o_iss_valid    (o_iss_valid),
    .i_iss_ready    (i_iss_ready),
    .o_iss_pc       (o_iss_pc),
    .o_iss_opcode   (o_iss_opcode),
    .o_iss_funct3   (o_iss_funct3),
    .o_iss_funct7   (o_iss_funct7),
    .o_iss_rd       (o_iss_rd),
    .o_iss_imm      (o_iss_imm),
    .o_iss_rs1_data (o_iss_rs1_data),
    .o_iss_rs2_data (o_iss_rs2_data),
    .o_iss_illegal  (o_iss_illegal)
  );

  always #5 i_clk = ~i_clk;

  // Register file: data appears the cycle after a request; unrequested ports return garbage.
  always @(posedge i_clk) begin
    i_read_data0 <= o_read0 ? {32'hD0D0_D0D0, 27'd0, o_read_addr0} : 64'hDEAD_BEEF_DEAD_BEEF;
    i_read_data1 <= o_read1 ? {32'hE1E1_E1E1, 27'd0, o_read_addr1} : 64'hDEAD_BEEF_DEAD_BEEF;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n      = 1'b0;
    i_inst_valid = 1'b0;
    i_inst       = 32'd0;
    i_pc         = 64'd0;
    i_wb_valid   = 1'b0;
    i_wb_addr    = 5'd0;
    i_iss_ready  = 1'b0;
    i_read_data0 = 64'd0;
    i_read_data1 = 64'd0;
    #2;
    tick();
    tick();
    chk("rst_iss_valid", {63'd0, o_iss_valid}, 64'd0);
    chk("rst_iss_imm", o_iss_imm, 64'd0);
    chk("rst_iss_rd", {59'd0, o_iss_rd}, 64'd0);
    chk("rst_read0", {63'd0, o_read0}, 64'd0);
    chk("rst_read_addr0", {59'd0, o_read_addr0}, 64'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rst_inst_ready", {63'd0, o_inst_ready}, 64'd1);

    // ADDI x5,x0,-1
    i_inst = 32'hFFF0_0293; i_pc = 64'h1000; i_inst_valid = 1'b1;
    tick();
    i_inst_valid = 1'b0;
    chk("addi_read0", {63'd0, o_read0}, 64'd1);
    chk("addi_read1", {63'd0, o_read1}, 64'd0);
    chk("addi_valid_early", {63'd0, o_iss_valid}, 64'd0);
    tick();
    chk("addi_valid_operand", {63'd0, o_iss_valid}, 64'd0);
    tick();
    chk("addi_valid", {63'd0, o_iss_valid}, 64'd1);
    chk("addi_imm", o_iss_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_rd", {59'd0, o_iss_rd}, 64'd5);
    chk("addi_pc", o_iss_pc, 64'h1000);
    chk("addi_opcode", {57'd0, o_iss_opcode}, 64'h13);
    chk("addi_rs1_data", o_iss_rs1_data, 64'hD0D0_D0D0_0000_0000);
    chk("addi_rs2_data", o_iss_rs2_data, 64'd0);

    // Execute back-pressure for three cycles
    for (int i = 0; i < 3; i++) begin
      chk("bp_inst_ready", {63'd0, o_inst_ready}, 64'd0);
      tick();
      chk("bp_valid", {63'd0, o_iss_valid}, 64'd1);
      chk("bp_imm", o_iss_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("bp_rd", {59'd0, o_iss_rd}, 64'd5);
    end

    // ADD x6,x5,x5 accepted on the ready cycle, must stall on x5
    i_iss_ready = 1'b1; i_inst = 32'h0052_8333; i_pc = 64'h1004; i_inst_valid = 1'b1;
    #1;
    chk("add_accept_ready", {63'd0, o_inst_ready}, 64'd1);
    tick();
    i_iss_ready = 1'b0; i_inst_valid = 1'b0;
    chk("add_iss_valid_drop", {63'd0, o_iss_valid}, 64'd0);
    chk("add_stall_read0", {63'd0, o_read0}, 64'd0);
    chk("add_stall_read1", {63'd0, o_read1}, 64'd0);
    chk("add_stall_addr0", {59'd0, o_read_addr0}, 64'd5);
    tick();
    chk("add_stall2_read0", {63'd0, o_read0}, 64'd0);
    i_wb_valid = 1'b1; i_wb_addr = 5'd5;
    #1;
    chk("add_wb_read0", {63'd0, o_read0}, 64'd1);
    chk("add_wb_read1", {63'd0, o_read1}, 64'd1);
    tick();
    i_wb_valid = 1'b0;
    tick();
    chk("add_valid", {63'd0, o_iss_valid}, 64'd1);
    chk("add_rs1_data", o_iss_rs1_data, 64'hD0D0_D0D0_0000_0005);
    chk("add_rs2_data", o_iss_rs2_data, 64'hE1E1_E1E1_0000_0005);
    chk("add_imm", o_iss_imm, 64'd0);
    chk("add_rd", {59'd0, o_iss_rd}, 64'd6);

    // SW x7,8(x2) accepted while ADD issues
    i_iss_ready = 1'b1; i_inst = 32'h0071_2423; i_pc = 64'h1008; i_inst_valid = 1'b1;
    tick();
    i_iss_ready = 1'b0; i_inst_valid = 1'b0;
    chk("sw_read0", {63'd0, o_read0}, 64'd1);
    chk("sw_read1", {63'd0, o_read1}, 64'd1);
    chk("sw_addr0", {59'd0, o_read_addr0}, 64'd2);
    chk("sw_addr1", {59'd0, o_read_addr1}, 64'd7);
    tick();
    tick();
    chk("sw_valid", {63'd0, o_iss_valid}, 64'd1);
    chk("sw_imm", o_iss_imm, 64'd8);
    chk("sw_funct3", {61'd0, o_iss_funct3}, 64'd2);
    chk("sw_rs1_data", o_iss_rs1_data, 64'hD0D0_D0D0_0000_0002);
    chk("sw_rs2_data", o_iss_rs2_data, 64'hE1E1_E1E1_0000_0007);

    // Illegal opcode 0x7F with rd=rs1=x8
    i_iss_ready = 1'b1; i_inst = 32'h0004_047F; i_pc = 64'h100C; i_inst_valid = 1'b1;
    tick();
    i_iss_ready = 1'b0; i_inst_valid = 1'b0;
    chk("ill_read0", {63'd0, o_read0}, 64'd0);
    chk("ill_read1", {63'd0, o_read1}, 64'd0);
    tick();
    tick();
    chk("ill_flag", {63'd0, o_iss_illegal}, 64'd1);
    chk("ill_imm", o_iss_imm, 64'd0);
    chk("ill_rs1_data", o_iss_rs1_data, 64'd0);

    // ADDI x9,x8,0: x8 must not be pending after the store and the illegal op
    i_iss_ready = 1'b1; i_inst = 32'h0004_0493; i_pc = 64'h1010; i_inst_valid = 1'b1;
    tick();
    i_iss_ready = 1'b0; i_inst_valid = 1'b0;
    chk("x8_nostall_read0", {63'd0, o_read0}, 64'd1);
    tick();
    tick();
    chk("x8_valid", {63'd0, o_iss_valid}, 64'd1);
    chk("x8_illegal", {63'd0, o_iss_illegal}, 64'd0);

    // Reset while holding in ISSUE; x6 and x9 are pending at this point
    i_rst_n = 1'b0;
    #1;
    chk("midrst_iss_valid", {63'd0, o_iss_valid}, 64'd0);
    chk("midrst_rd", {59'd0, o_iss_rd}, 64'd0);
    tick();
    i_rst_n = 1'b1;
    #1;
    chk("midrst_inst_ready", {63'd0, o_inst_ready}, 64'd1);

    // ADD x10,x6,x9 must not stall once the scoreboard is cleared
    i_inst = 32'h0093_0533; i_pc = 64'h2000; i_inst_valid = 1'b1;
    tick();
    i_inst_valid = 1'b0;
    chk("post_rst_read0", {63'd0, o_read0}, 64'd1);
    chk("post_rst_read1", {63'd0, o_read1}, 64'd1);
    tick();
    tick();
    chk("post_rst_valid", {63'd0, o_iss_valid}, 64'd1);
    chk("post_rst_rs1_data", o_iss_rs1_data, 64'hD0D0_D0D0_0000_0006);
    chk("post_rst_rs2_data", o_iss_rs2_data, 64'hE1E1_E1E1_0000_0009);

    // LUI x11,0x80000: U-type sign extension, no reads
    i_iss_ready = 1'b1; i_inst = 32'h8000_05B7; i_pc = 64'h2004; i_inst_valid = 1'b1;
    tick();
    i_iss_ready = 1'b0; i_inst_valid = 1'b0;
    chk("lui_read0", {63'd0, o_read0}, 64'd0);
    tick();
    tick();
    chk("lui_imm", o_iss_imm, 64'hFFFF_FFFF_8000_0000);
    chk("lui_rd", {59'd0, o_iss_rd}, 64'd11);
    chk("lui_rs1_data", o_iss_rs1_data, 64'd0);

    // Issue with no new instruction returns to IDLE
    i_iss_ready = 1'b1;
    tick();
    i_iss_ready = 1'b0;
    chk("idle_valid", {63'd0, o_iss_valid}, 64'd0);
    chk("idle_inst_ready", {63'd0, o_inst_ready}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
